// File: rtl/arm_mem_pkg.sv
// Shared constants and FSM state type for the SRAM-backed data-memory controller.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    localparam int unsigned SRAM_DW   = 16;
    localparam int unsigned SRAM_AW   = 18;
    localparam logic [31:0] DATA_BASE = 32'd1024;

endpackage

// File: rtl/sram_phase_timer.sv
// Wait-state counter for one SRAM halfword phase; `last` flags the final cycle of the phase.
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (clear) begin
            r_cnt <= 4'd0;
        end else if (enable) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign last = (r_cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Pipeline data-memory stage on an external async SRAM: each 32-bit word is two 16-bit phases.
// Optional macro SRAM_ADDR_REMAP_EN maps byte address DATA_BASE onto SRAM word 0.
module sram_mem_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = arm_mem_pkg::SRAM_AW,
    parameter int SRAM_DW     = arm_mem_pkg::SRAM_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    import arm_mem_pkg::*;

    mem_state_e           r_state;
    mem_state_e           w_state_next;
    logic [31:0]          r_read_data;
    logic [31:0]          w_eff_addr;
    logic                 w_req;
    logic                 w_load;
    logic                 w_busy;
    logic                 w_drive;
    logic                 w_last;
    logic [SRAM_DW-1:0]   w_dq_out;
    logic                 w_unused_addr;

`ifdef SRAM_ADDR_REMAP_EN
    // Wraps silently: addresses below DATA_BASE alias the top of SRAM.
    assign w_eff_addr = address - DATA_BASE;
`else
    assign w_eff_addr = address;
`endif

    assign w_unused_addr = ^{w_eff_addr[31:SRAM_AW+1], w_eff_addr[1:0]};

    assign w_req   = rd_en | wr_en;
    assign w_load  = rd_en & ~wr_en;
    assign w_busy  = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_drive = w_busy & wr_en;

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (~w_busy | w_last),
        .enable (w_busy),
        .last   (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req) w_state_next = S_LOW;
            S_LOW:   if (w_last) w_state_next = S_HIGH;
            S_HIGH:  if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Each halfword is captured on the final wait-state cycle of its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_data <= 32'd0;
        end else if (w_load && w_last) begin
            if (r_state == S_LOW) begin
                r_read_data[15:0] <= SRAM_DQ;
            end else if (r_state == S_HIGH) begin
                r_read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        SRAM_ADDR = '0;
        w_dq_out  = write_data[15:0];
        if (r_state == S_LOW) begin
            SRAM_ADDR = {w_eff_addr[SRAM_AW:2], 1'b0};
        end else if (r_state == S_HIGH) begin
            SRAM_ADDR = {w_eff_addr[SRAM_AW:2], 1'b1};
            w_dq_out  = write_data[31:16];
        end
    end

    assign SRAM_DQ   = w_drive ? w_dq_out : {SRAM_DW{1'bz}};
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign ready     = ~w_req | (r_state == S_DONE);
    assign read_data = r_read_data;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: SRAM device model plus a word-level reference memory.
module tb_sram_mem_ctrl;

    localparam int W  = 2;
    localparam int AW = 18;

`ifdef SRAM_ADDR_REMAP_EN
    localparam logic [31:0] BASE = 32'd1024;
`else
    localparam logic [31:0] BASE = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   address = 32'd0;
    logic [31:0]   write_data = 32'd0;
    logic [31:0]   read_data;
    logic          ready;
    wire  [15:0]   SRAM_DQ;
    logic [AW-1:0] SRAM_ADDR;
    logic          SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;

    // Device side: bus reads back all-ones whenever nobody drives it.
    logic          dev_en = 1'b0;
    logic [15:0]   dev_mem [0:(1<<AW)-1];

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (SRAM_DQ[g]);
    end

    assign SRAM_DQ = (dev_en && SRAM_WE_N && !SRAM_OE_N && !SRAM_CE_N) ?
                     dev_mem[SRAM_ADDR] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_WE_N && !SRAM_CE_N) dev_mem[SRAM_ADDR] <= SRAM_DQ;
    end

    always #5 clk = ~clk;

    sram_mem_ctrl #(
        .WAIT_CYCLES (W),
        .SRAM_AW     (AW),
        .SRAM_DW     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [int];
    logic [31:0] exp_rd = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] eff;
        eff = addr - BASE;
        return int'((eff >> 2) & 32'h1FFFF);
    endfunction

    // One pipeline instruction; called just after a rising edge, returns just after one.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
        bit   is_store, is_load;
        int   wd, total;
        logic [31:0] exp_addr;
        logic [15:0] exp_dq;
        is_store   = wr;
        is_load    = rd && !wr;
        wd         = word_of(addr);
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        dev_en     = is_load;
        if (!rd && !wr) begin
            @(negedge clk);
            check("nop_ready", {31'd0, ready}, 32'd1);
            check("nop_we_n", {31'd0, SRAM_WE_N}, 32'd1);
            check("nop_addr", {14'd0, SRAM_ADDR}, 32'd0);
            check("nop_dq", {16'd0, SRAM_DQ}, 32'h0000FFFF);
            @(posedge clk); #1;
            return;
        end
        total = 2 * W + 2;
        for (int c = 0; c < total; c++) begin
            bit in_lo, in_hi;
            in_lo = (c >= 1) && (c <= W);
            in_hi = (c > W) && (c <= 2 * W);
            exp_addr = in_lo ? 32'(wd * 2) : (in_hi ? 32'(wd * 2 + 1) : 32'd0);
            @(negedge clk);
            check($sformatf("ready_c%0d", c), {31'd0, ready}, {31'd0, c == total - 1});
            check($sformatf("addr_c%0d", c), {14'd0, SRAM_ADDR}, exp_addr);
            check($sformatf("we_n_c%0d", c), {31'd0, SRAM_WE_N},
                  {31'd0, !(is_store && (in_lo || in_hi))});
            if (is_store) begin
                exp_dq = in_lo ? data[15:0] : (in_hi ? data[31:16] : 16'hFFFF);
                check($sformatf("dq_c%0d", c), {16'd0, SRAM_DQ}, {16'd0, exp_dq});
            end
            if (c == total - 1) begin
                if (is_load) exp_rd = model_mem[wd];
                check("read_data_done", read_data, exp_rd);
            end
            @(posedge clk); #1;
        end
        if (is_store) model_mem[wd] = data;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        dev_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("rst_dq", {16'd0, SRAM_DQ}, 32'h0000FFFF);
        check("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        @(posedge clk); #1;

        access(1'b0, 1'b1, BASE + 32'd4, 32'hDEADBEEF);
        access(1'b1, 1'b0, BASE + 32'd4, 32'h0);
        access(1'b0, 1'b1, BASE + 32'd8, 32'h12345678);
        access(1'b0, 1'b1, BASE + 32'd12, 32'hCAFEF00D);
        access(1'b1, 1'b0, BASE + 32'd8, 32'h0);
        access(1'b1, 1'b0, BASE + 32'd12, 32'h0);
        access(1'b0, 1'b0, BASE + 32'd8, 32'h0);

        // Both enables: store wins and read_data is left alone.
        access(1'b1, 1'b1, BASE + 32'd8, 32'hA5A55A5A);
        access(1'b1, 1'b0, BASE + 32'd8, 32'h0);

        // Reset during the HIGH phase of a store to word 100.
        rd_en = 1'b0; wr_en = 1'b1; dev_en = 1'b0;
        address = BASE + 32'd400; write_data = 32'h0BADCAFE;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        check("pre_rst_high_addr", {14'd0, SRAM_ADDR}, 32'd201);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        check("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check("midrst_dq", {16'd0, SRAM_DQ}, 32'h0000FFFF);
        check("midrst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check("midrst_read_data", read_data, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd1);
        exp_rd = 32'd0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, BASE + 32'd4, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int          kind, off;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            off  = int'($urandom_range(1, 31));
            a    = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            if (kind == 1 && !model_mem.exists(word_of(a))) kind = 2;
            case (kind)
                0:       access(1'b0, 1'b0, a, $urandom);
                1:       access(1'b1, 1'b0, a, $urandom);
                2:       access(1'b0, 1'b1, a, $urandom);
                default: access(1'b1, 1'b1, a, $urandom);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
